// File: rtl/alu_rs_pkg.sv
// Shared definitions for the integer reservation station: default sizes,
// micro-op encodings and the branch-condition helper used by the ALU.
package alu_rs_pkg;

  localparam int RS_DEPTH_DEF  = 8;
  localparam int ROB_ID_W_DEF  = 4;
  localparam int OP_W_DEF      = 6;
  localparam int CDB_PORTS_DEF = 1;

  // Micro-op encodings, compared against the zero-extended op code.
  // Loads/stores keep their slots in the numbering but are not executed here.
  localparam logic [31:0] OP_LUI   = 32'd0;
  localparam logic [31:0] OP_AUIPC = 32'd1;
  localparam logic [31:0] OP_JAL   = 32'd2;
  localparam logic [31:0] OP_JALR  = 32'd3;
  localparam logic [31:0] OP_BEQ   = 32'd4;
  localparam logic [31:0] OP_BNE   = 32'd5;
  localparam logic [31:0] OP_BLT   = 32'd6;
  localparam logic [31:0] OP_BGE   = 32'd7;
  localparam logic [31:0] OP_BLTU  = 32'd8;
  localparam logic [31:0] OP_BGEU  = 32'd9;
  localparam logic [31:0] OP_LB    = 32'd10;
  localparam logic [31:0] OP_LH    = 32'd11;
  localparam logic [31:0] OP_LW    = 32'd12;
  localparam logic [31:0] OP_LBU   = 32'd13;
  localparam logic [31:0] OP_LHU   = 32'd14;
  localparam logic [31:0] OP_SB    = 32'd15;
  localparam logic [31:0] OP_SH    = 32'd16;
  localparam logic [31:0] OP_SW    = 32'd17;
  localparam logic [31:0] OP_ADDI  = 32'd18;
  localparam logic [31:0] OP_SLTI  = 32'd19;
  localparam logic [31:0] OP_SLTIU = 32'd20;
  localparam logic [31:0] OP_XORI  = 32'd21;
  localparam logic [31:0] OP_ORI   = 32'd22;
  localparam logic [31:0] OP_ANDI  = 32'd23;
  localparam logic [31:0] OP_SLLI  = 32'd24;
  localparam logic [31:0] OP_SRLI  = 32'd25;
  localparam logic [31:0] OP_SRAI  = 32'd26;
  localparam logic [31:0] OP_ADD   = 32'd27;
  localparam logic [31:0] OP_SUB   = 32'd28;
  localparam logic [31:0] OP_SLL   = 32'd29;
  localparam logic [31:0] OP_SLT   = 32'd30;
  localparam logic [31:0] OP_SLTU  = 32'd31;
  localparam logic [31:0] OP_XOR   = 32'd32;
  localparam logic [31:0] OP_SRL   = 32'd33;
  localparam logic [31:0] OP_SRA   = 32'd34;
  localparam logic [31:0] OP_OR    = 32'd35;
  localparam logic [31:0] OP_AND   = 32'd36;

  // Conditional-branch outcome; non-branch ops report not taken.
  function automatic logic br_cond(input logic [31:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (op)
      OP_BEQ:  r = (a == b);
      OP_BNE:  r = (a != b);
      OP_BLT:  r = ($signed(a) < $signed(b));
      OP_BGE:  r = ($signed(a) >= $signed(b));
      OP_BLTU: r = (a < b);
      OP_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_exec.sv
// Combinational integer ALU with branch/jump resolution. The caller registers
// the outputs.
module alu_rs_exec
  import alu_rs_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     vj,
  input  logic [31:0]     vk,
  input  logic [31:0]     imm,
  input  logic [31:0]     pc,
  output logic [31:0]     value,
  output logic            taken,
  output logic [31:0]     target
);

  logic [31:0] op_ext;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic        cond;

  assign op_ext   = 32'(op);
  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;
  assign cond     = br_cond(op_ext, vj, vk);

  // Decode the op into result value, taken flag and next PC.
  always_comb begin
    value  = 32'd0;
    taken  = 1'b0;
    target = pc_plus4;
    case (op_ext)
      OP_LUI:   value = imm;
      OP_AUIPC: value = pc_imm;
      OP_JAL: begin
        value  = pc_plus4;
        taken  = 1'b1;
        target = pc_imm;
      end
      OP_JALR: begin
        value  = pc_plus4;
        taken  = 1'b1;
        target = (vj + imm) & 32'hFFFF_FFFE;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        value  = {31'd0, cond};
        taken  = cond;
        target = cond ? pc_imm : pc_plus4;
      end
      OP_ADDI:  value = vj + imm;
      OP_SLTI:  value = {31'd0, $signed(vj) < $signed(imm)};
      OP_SLTIU: value = {31'd0, vj < imm};
      OP_XORI:  value = vj ^ imm;
      OP_ORI:   value = vj | imm;
      OP_ANDI:  value = vj & imm;
      OP_SLLI:  value = vj << imm[4:0];
      OP_SRLI:  value = vj >> imm[4:0];
      OP_SRAI:  value = $unsigned($signed(vj) >>> imm[4:0]);
      OP_ADD:   value = vj + vk;
      OP_SUB:   value = vj - vk;
      OP_SLL:   value = vj << vk[4:0];
      OP_SLT:   value = {31'd0, $signed(vj) < $signed(vk)};
      OP_SLTU:  value = {31'd0, vj < vk};
      OP_XOR:   value = vj ^ vk;
      OP_SRL:   value = vj >> vk[4:0];
      OP_SRA:   value = $unsigned($signed(vj) >>> vk[4:0]);
      OP_OR:    value = vj | vk;
      OP_AND:   value = vj & vk;
      default:  value = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_rs.sv
// Integer/branch reservation station: buffers micro-ops until both operands
// are ready, issues the lowest ready entry each cycle into a registered ALU
// and snoops external CDB ports plus its own result bus for wakeup.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int ROB_ID_W  = ROB_ID_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int CDB_PORTS = CDB_PORTS_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  output logic                      rs_full,
  input  logic                      disp_valid,
  input  logic [OP_W-1:0]           disp_op,
  input  logic                      disp_j_rdy,
  input  logic                      disp_k_rdy,
  input  logic [31:0]               disp_vj,
  input  logic [31:0]               disp_vk,
  input  logic [ROB_ID_W-1:0]       disp_qj,
  input  logic [ROB_ID_W-1:0]       disp_qk,
  input  logic [ROB_ID_W-1:0]       disp_rob_id,
  input  logic [31:0]               disp_imm,
  input  logic [31:0]               disp_pc,
  input  logic [CDB_PORTS-1:0]      cdb_valid,
  input  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*32-1:0]   cdb_value,
  output logic                      out_valid,
  output logic [ROB_ID_W-1:0]       out_rob_id,
  output logic [31:0]               out_value,
  output logic                      out_taken,
  output logic [31:0]               out_target
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0] valid_q, valid_d, jr_q, jr_d, kr_q, kr_d;
  logic [OP_W-1:0]     op_q  [RS_DEPTH];
  logic [OP_W-1:0]     op_d  [RS_DEPTH];
  logic [31:0]         vj_q  [RS_DEPTH];
  logic [31:0]         vj_d  [RS_DEPTH];
  logic [31:0]         vk_q  [RS_DEPTH];
  logic [31:0]         vk_d  [RS_DEPTH];
  logic [31:0]         imm_q [RS_DEPTH];
  logic [31:0]         imm_d [RS_DEPTH];
  logic [31:0]         pc_q  [RS_DEPTH];
  logic [31:0]         pc_d  [RS_DEPTH];
  logic [ROB_ID_W-1:0] qj_q  [RS_DEPTH];
  logic [ROB_ID_W-1:0] qj_d  [RS_DEPTH];
  logic [ROB_ID_W-1:0] qk_q  [RS_DEPTH];
  logic [ROB_ID_W-1:0] qk_d  [RS_DEPTH];
  logic [ROB_ID_W-1:0] rob_q [RS_DEPTH];
  logic [ROB_ID_W-1:0] rob_d [RS_DEPTH];
  logic [CNT_W-1:0]    count_q, count_d;

  logic                out_valid_q, out_valid_d, out_taken_q, out_taken_d;
  logic [ROB_ID_W-1:0] out_rob_id_q, out_rob_id_d;
  logic [31:0]         out_value_q, out_value_d, out_target_q, out_target_d;

  logic [32:0]         snoop_j [RS_DEPTH];
  logic [32:0]         snoop_k [RS_DEPTH];
  logic [32:0]         disp_sj, disp_sk;
  logic                issue_hit, alloc_hit, accept;
  logic [IDX_W-1:0]    issue_idx, alloc_idx;
  logic [31:0]         ex_value, ex_target;
  logic                ex_taken;

  // Tag match against CDB ports and the registered self-broadcast.
  // Returns {hit, value}; lower CDB ports override higher ones and the self bus.
  function automatic logic [32:0] snoop(input logic [ROB_ID_W-1:0] tag);
    logic [32:0] r;
    r = 33'd0;
    if (out_valid_q && out_rob_id_q == tag) r = {1'b1, out_value_q};
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && cdb_rob_id[p*ROB_ID_W +: ROB_ID_W] == tag)
        r = {1'b1, cdb_value[p*32 +: 32]};
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_snoop
    assign snoop_j[gi] = snoop(qj_q[gi]);
    assign snoop_k[gi] = snoop(qk_q[gi]);
  end

  assign disp_sj = snoop(disp_qj);
  assign disp_sk = snoop(disp_qk);
  assign rs_full = (count_q == CNT_W'(RS_DEPTH));
  assign accept  = disp_valid && !rs_full && alloc_hit;

  // Lowest-index ready entry for issue and lowest-index free entry for dispatch.
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && jr_q[i] && kr_q[i]) begin
        issue_hit = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  alu_rs_exec #(.OP_W(OP_W)) u_exec (
    .op     (op_q[issue_idx]),
    .vj     (vj_q[issue_idx]),
    .vk     (vk_q[issue_idx]),
    .imm    (imm_q[issue_idx]),
    .pc     (pc_q[issue_idx]),
    .value  (ex_value),
    .taken  (ex_taken),
    .target (ex_target)
  );

  // Next state: flush clears, pause holds, otherwise wakeup + issue + dispatch.
  always_comb begin
    valid_d = valid_q;  jr_d = jr_q;  kr_d = kr_q;
    op_d = op_q;  vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;  pc_d = pc_q;
    qj_d = qj_q;  qk_d = qk_q;  rob_d = rob_q;
    count_d      = count_q;
    out_valid_d  = 1'b0;
    out_rob_id_d = out_rob_id_q;
    out_value_d  = out_value_q;
    out_taken_d  = out_taken_q;
    out_target_d = out_target_q;
    if (flush_in) begin
      valid_d = '0;
      count_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && !jr_q[i] && snoop_j[i][32]) begin
          jr_d[i] = 1'b1;
          vj_d[i] = snoop_j[i][31:0];
        end
        if (valid_q[i] && !kr_q[i] && snoop_k[i][32]) begin
          kr_d[i] = 1'b1;
          vk_d[i] = snoop_k[i][31:0];
        end
      end
      if (issue_hit) begin
        valid_d[issue_idx] = 1'b0;
        out_valid_d  = 1'b1;
        out_rob_id_d = rob_q[issue_idx];
        out_value_d  = ex_value;
        out_taken_d  = ex_taken;
        out_target_d = ex_target;
      end
      // The new entry is written from valid_q, so it cannot issue before next cycle.
      if (accept) begin
        valid_d[alloc_idx] = 1'b1;
        op_d[alloc_idx]    = disp_op;
        jr_d[alloc_idx]    = disp_j_rdy | disp_sj[32];
        kr_d[alloc_idx]    = disp_k_rdy | disp_sk[32];
        vj_d[alloc_idx]    = disp_j_rdy ? disp_vj : disp_sj[31:0];
        vk_d[alloc_idx]    = disp_k_rdy ? disp_vk : disp_sk[31:0];
        qj_d[alloc_idx]    = disp_qj;
        qk_d[alloc_idx]    = disp_qk;
        imm_d[alloc_idx]   = disp_imm;
        pc_d[alloc_idx]    = disp_pc;
        rob_d[alloc_idx]   = disp_rob_id;
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue_hit);
    end
  end

  // Control state and result registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q      <= '0;
      jr_q         <= '0;
      kr_q         <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= 32'd0;
      out_taken_q  <= 1'b0;
      out_target_q <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      jr_q         <= jr_d;
      kr_q         <= kr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_rob_id_q <= out_rob_id_d;
      out_value_q  <= out_value_d;
      out_taken_q  <= out_taken_d;
      out_target_q <= out_target_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    op_q  <= op_d;   vj_q <= vj_d;  vk_q <= vk_d;  imm_q <= imm_d;
    pc_q  <= pc_d;   qj_q <= qj_d;  qk_q <= qk_d;  rob_q <= rob_d;
  end

  assign out_valid  = out_valid_q;
  assign out_rob_id = out_rob_id_q;
  assign out_value  = out_value_q;
  assign out_taken  = out_taken_q;
  assign out_target = out_target_q;

endmodule
